// File: rtl/flash_reader.sv
// Audio sample fetcher: one 32-bit flash read per trigger, one 16-bit half per sample,
// address advanced after both halves. Define FLASHREADER_REVERSE_EN for reverse playback.
module flash_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        flsh_waitrequest,
  output logic        flsh_read,
  input  logic [31:0] flsh_readdata,
  input  logic        flsh_readdatavalid,
  output logic [3:0]  flsh_byteenable,
  output logic        address_inc,
  output logic        address_dec,
  output logic        address_rst,
  output logic        audio_enable,
  output logic [15:0] audio_out,
  input  logic        startsamplenow
);

  typedef enum logic [2:0] {INIT, IDLE, READ, WAITDATA, OUTPUT} state_t;

  state_t      state, state_nxt;
  logic        half;
  logic [15:0] sample_sel;
  logic        step_pulse;

  assign flsh_byteenable = 4'b1111;

`ifdef FLASHREADER_REVERSE_EN
  assign sample_sel = half ? flsh_readdata[15:0] : flsh_readdata[31:16];
`else
  assign sample_sel = half ? flsh_readdata[31:16] : flsh_readdata[15:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    flsh_read    = 1'b0;
    audio_enable = 1'b0;
    step_pulse   = 1'b0;
    case (state)
      INIT:     state_nxt = IDLE;
      IDLE:     if (startsamplenow) state_nxt = READ;
      READ: begin
        flsh_read = 1'b1;
        if (!flsh_waitrequest) state_nxt = WAITDATA;
      end
      WAITDATA: if (flsh_readdatavalid) state_nxt = OUTPUT;
      OUTPUT: begin
        audio_enable = 1'b1;
        step_pulse   = half;
        state_nxt    = IDLE;
      end
      default:  state_nxt = INIT;
    endcase
  end

`ifdef FLASHREADER_REVERSE_EN
  assign address_inc = 1'b0;
  assign address_dec = step_pulse;
`else
  assign address_inc = step_pulse;
  assign address_dec = 1'b0;
`endif

  // INIT is also the state held during reset; gating with rst keeps the pulse
  // to the first cycle after release only.
  assign address_rst = (state == INIT) & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      audio_out <= 16'h0000;
      half      <= 1'b0;
    end else begin
      if (state == WAITDATA && flsh_readdatavalid) audio_out <= sample_sel;
      if (state == OUTPUT) half <= ~half;
    end
  end

endmodule

// File: tb/tb_flash_reader.sv
// Self-checking bench for flash_reader: directed cases plus randomized transactions
// against a word/half-level playback model.
module tb_flash_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flsh_waitrequest = 1'b0;
  logic        flsh_read;
  logic [31:0] flsh_readdata = 32'h0;
  logic        flsh_readdatavalid = 1'b0;
  logic [3:0]  flsh_byteenable;
  logic        address_inc, address_dec, address_rst, audio_enable;
  logic [15:0] audio_out;
  logic        startsamplenow = 1'b0;

  int total = 0;
  int bad   = 0;

  // model: which half of the current word comes next, last delivered sample
  int          m_half = 0;
  logic [15:0] m_audio = 16'h0;

  flash_reader dut (
    .clk(clk), .rst(rst),
    .flsh_waitrequest(flsh_waitrequest), .flsh_read(flsh_read),
    .flsh_readdata(flsh_readdata), .flsh_readdatavalid(flsh_readdatavalid),
    .flsh_byteenable(flsh_byteenable),
    .address_inc(address_inc), .address_dec(address_dec), .address_rst(address_rst),
    .audio_enable(audio_enable), .audio_out(audio_out),
    .startsamplenow(startsamplenow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_en"},  {31'b0, audio_enable}, 32'd0);
    chk({tag, "_inc"}, {31'b0, address_inc},  32'd0);
    chk({tag, "_dec"}, {31'b0, address_dec},  32'd0);
    chk({tag, "_rst"}, {31'b0, address_rst},  32'd0);
  endtask

  // One sample: trigger, `waits` flash stall cycles, `delay` data delay cycles.
  task automatic do_sample(input logic [31:0] data, input int waits, input int delay,
                           input bit hold);
    logic [15:0] exp_s;
    bit          exp_step;
    startsamplenow   = 1'b1;
    flsh_waitrequest = (waits > 0);
    tick();
    if (!hold) startsamplenow = 1'b0;
    for (int i = 0; i < waits; i++) begin
      chk("read_stall", {31'b0, flsh_read}, 32'd1);
      tick();
      flsh_waitrequest = (i + 1 < waits);
    end
    flsh_waitrequest = 1'b0;
    chk("read_accept", {31'b0, flsh_read}, 32'd1);
    tick();
    for (int j = 0; j < delay; j++) begin
      chk("read_drop", {31'b0, flsh_read}, 32'd0);
      chk("en_early", {31'b0, audio_enable}, 32'd0);
      flsh_readdata = $urandom;
      if (!hold) startsamplenow = $urandom_range(0, 1);
      tick();
    end
    chk("read_drop2", {31'b0, flsh_read}, 32'd0);
    if (!hold) startsamplenow = 1'b0;
    flsh_readdatavalid = 1'b1;
    flsh_readdata      = data;
    tick();
    flsh_readdatavalid = 1'b0;
    flsh_readdata      = $urandom;
`ifdef FLASHREADER_REVERSE_EN
    exp_s = (m_half == 0) ? data[31:16] : data[15:0];
`else
    exp_s = (m_half == 0) ? data[15:0] : data[31:16];
`endif
    exp_step = (m_half == 1);
    m_half   = 1 - m_half;
    m_audio  = exp_s;
    chk("audio", {16'b0, audio_out}, {16'b0, exp_s});
    chk("en", {31'b0, audio_enable}, 32'd1);
`ifdef FLASHREADER_REVERSE_EN
    chk("dec", {31'b0, address_dec}, {31'b0, exp_step});
    chk("inc_rev", {31'b0, address_inc}, 32'd0);
`else
    chk("inc", {31'b0, address_inc}, {31'b0, exp_step});
    chk("dec_fwd", {31'b0, address_dec}, 32'd0);
`endif
    chk("read_out", {31'b0, flsh_read}, 32'd0);
    tick();
    chk_quiet("idle");
    chk("read_idle", {31'b0, flsh_read}, 32'd0);
    chk("audio_hold", {16'b0, audio_out}, {16'b0, m_audio});
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_pulse", {31'b0, address_rst}, 32'd1);
    chk("arst_read", {31'b0, flsh_read}, 32'd0);
    chk("arst_en", {31'b0, audio_enable}, 32'd0);
    tick();
    chk("arst_drop", {31'b0, address_rst}, 32'd0);
    m_half  = 0;
    m_audio = 16'h0;
  endtask

  initial begin
    #2;
    chk("rst_audio", {16'b0, audio_out}, 32'd0);
    chk("rst_be", {28'b0, flsh_byteenable}, 32'hF);
    chk("rst_read", {31'b0, flsh_read}, 32'd0);
    chk_quiet("rst");
    reset_release();

    // directed: two halves of one word, then a stalled read
    do_sample(32'hDEADBEEF, 0, 5, 1'b0);
    do_sample(32'hDEADBEEF, 0, 0, 1'b0);
    do_sample(32'h12345678, 3, 1, 1'b0);

    // readdatavalid in IDLE must be ignored
    flsh_readdatavalid = 1'b1;
    flsh_readdata      = 32'hA5A5A5A5;
    tick();
    flsh_readdatavalid = 1'b0;
    chk("idle_valid_audio", {16'b0, audio_out}, {16'b0, m_audio});
    chk("idle_valid_en", {31'b0, audio_enable}, 32'd0);

    // held trigger: back-to-back reads
    do_sample(32'hCAFEF00D, 0, 2, 1'b1);
    do_sample(32'hCAFEF00D, 1, 0, 1'b1);
    startsamplenow = 1'b0;

    // reset during WAITDATA
    startsamplenow = 1'b1;
    tick();
    startsamplenow = 1'b0;
    tick();
    flsh_readdata = 32'h0BAD0BAD;
    rst = 1'b0;
    #1;
    chk("mid_rst_audio", {16'b0, audio_out}, 32'd0);
    chk("mid_rst_read", {31'b0, flsh_read}, 32'd0);
    chk("mid_rst_be", {28'b0, flsh_byteenable}, 32'hF);
    chk_quiet("mid_rst");
    reset_release();
    do_sample(32'hDEADBEEF, 0, 1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 40; n++)
      do_sample($urandom, $urandom_range(0, 3), $urandom_range(0, 4), ($urandom_range(0, 3) == 0));
    startsamplenow = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flash_reader.md
# flash_reader

Audio sample fetcher between the flash memory (Avalon-MM-style read master), the external flash address counter, and the audio output register. Each sample trigger performs one 32-bit flash read and delivers one 16-bit half of the word as an audio sample. Two samples are taken from each word, then the address counter is advanced. Sits between the slow-clock sample trigger and the audio codec path.

## Interface
- No parameters.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flsh_waitrequest  in  1  flash not ready; a read is accepted only in a cycle where this is 0.
- flsh_read  out  1  read request; held until accepted.
- flsh_readdata  in  32  read data; valid when flsh_readdatavalid=1.
- flsh_readdatavalid  in  1  one-cycle data-valid strobe.
- flsh_byteenable  out  4  constant 4'b1111.
- address_inc  out  1  one-cycle pulse: advance the flash word address.
- address_dec  out  1  one-cycle pulse: step the flash word address back.
- address_rst  out  1  one-cycle pulse: return the flash address to its start.
- audio_enable  out  1  one-cycle strobe: audio_out holds a new sample.
- audio_out  out  16  current sample, registered.
- startsamplenow  in  1  level-sensitive sample trigger, sampled only in IDLE.

## Operation
- States: INIT, IDLE, READ, WAITDATA, OUTPUT.
- INIT: address_rst=1 for exactly one cycle, then IDLE.
- IDLE: if startsamplenow=1, go to READ; otherwise stay.
- READ: flsh_read=1. If flsh_waitrequest=0, go to WAITDATA; otherwise stay in READ with flsh_read held.
- WAITDATA: flsh_read=0. On flsh_readdatavalid=1, load the selected half into audio_out and go to OUTPUT.
  - half=0 selects flsh_readdata[15:0].
  - half=1 selects flsh_readdata[31:16].
- OUTPUT, one cycle:
  - audio_enable=1.
  - If half=1, address_inc=1.
  - Toggle half, then go to IDLE.
- Reset state is INIT.
- Reset values:
  - flsh_read=0, audio_enable=0, address_inc=0, address_dec=0, address_rst=0.
  - audio_out=16'h0000, half=0.
- flsh_byteenable=4'b1111 at all times, including during reset.
- startsamplenow is ignored outside IDLE. If it is still high on return to IDLE, a new read starts.
- flsh_readdatavalid is ignored outside WAITDATA.
- Reset asserted mid-operation: every output takes its reset value immediately. Any pending read is abandoned, and the FSM restarts at INIT when reset is released.
- address_inc, address_dec and address_rst are never high in the same cycle.

## Timing
- Edge E samples startsamplenow=1 in IDLE → flsh_read=1 in cycle E+1.
- Waitrequest low at edge E+1 → flsh_read=0 from E+1 onward; state is WAITDATA.
- readdatavalid sampled at edge D:
  - audio_out updated at D.
  - audio_enable (and address_inc when applicable) high for the cycle D to D+1.
  - IDLE at D+1.
- Minimum trigger-to-audio_enable latency with zero wait: 3 cycles.
- Each flash wait cycle adds one cycle; each cycle of data delay adds one cycle.
- First cycle after reset release: address_rst=1.

## Configuration
- Macro FLASHREADER_REVERSE_EN.
- Defined (reverse playback):
  - half=0 selects [31:16] and half=1 selects [15:0].
  - OUTPUT with half=1 pulses address_dec instead of address_inc.
- Undefined (forward playback):
  - Behaviour is as described in Operation.
  - address_dec is tied to 0.

## Test plan
- Reset release → address_rst=1 for one cycle. All other outputs and audio_out=0. flsh_byteenable=4'hF.
- Forward playback, flsh_readdata=32'hDEADBEEF, no wait, startsamplenow pulsed for one cycle:
  - flsh_read high for one cycle.
  - readdatavalid 5 cycles later → audio_out=16'hBEEF with audio_enable for one cycle, no address pulse.
- Same setup, second trigger → audio_out=16'hDEAD, audio_enable and address_inc together for one cycle. half returns to 0.
- flsh_waitrequest=1 for 3 cycles during READ → flsh_read stays high all 4 cycles, then drops. Sample delivery slips by 3 cycles.
- startsamplenow held high → back-to-back reads. A pulse during WAITDATA does not start a second read.
- Reset asserted during WAITDATA → outputs clear immediately. After release: INIT, address_rst pulse, and the next sample is 16'hBEEF.
- With FLASHREADER_REVERSE_EN, readdata 32'hDEADBEEF → 16'hDEAD first, then 16'hBEEF with address_dec. address_inc never asserted.
